// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph table, segment bit positions and scan state encoding
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-low a..g patterns, element 0 is the glyph for hex 0
    localparam logic [15:0][6:0] GLYPHS = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low a..g decode
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = hex_glyph(nibble_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan with blanking and frame-aligned loads
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 50000,
    parameter int BLANK  = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_out,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_e          state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        phase_q, phase_d;
    logic [4*DIGITS-1:0]  disp_val_q, disp_val_d;
    logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
    logic [4*DIGITS-1:0]  pend_val_q, pend_val_d;
    logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
    logic                 pend_q, pend_d;
    logic [7:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    dig_q, dig_d;
    logic                 tick_q, tick_d;
    logic                 ready_q, ready_d;

    logic                 boundary;
    logic                 load_fire;
    logic [3:0]           scan_nibble;
    logic [6:0]           glyph_n;

    assign load_fire = load_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q + 1'b1;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_d     = pend_q;
        boundary   = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (phase_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    phase_d = '0;
                end
            end
            ST_DRIVE: begin
                if (phase_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    phase_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                phase_d = '0;
            end
        endcase

        // Pending only moves to the display on the wrap so a frame never mixes values
        if (boundary && pend_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            pend_d     = 1'b0;
        end

        if (load_fire) begin
            pend_val_d = value_in;
            pend_dp_d  = dp_in;
            pend_d     = 1'b1;
        end

        tick_d  = boundary;
        // Ready stays low through the apply cycle and reopens one cycle later
        ready_d = !pend_d && !(boundary && pend_q);
    end

    assign scan_nibble = disp_val_d[int'(idx_d)*4 +: 4];

    seg7_hex_decode u_decode (
        .nibble_i (scan_nibble),
        .seg_n_o  (glyph_n)
    );

    always_comb begin
        seg_d = SEG_OFF;
        dig_d = '1;
        if (state_d == ST_DRIVE) begin
            dig_d[idx_d]  = 1'b0;
            seg_d[SEG_A]  = glyph_n[6];
            seg_d[SEG_B]  = glyph_n[5];
            seg_d[SEG_C]  = glyph_n[4];
            seg_d[SEG_D]  = glyph_n[3];
            seg_d[SEG_E]  = glyph_n[2];
            seg_d[SEG_F]  = glyph_n[1];
            seg_d[SEG_G]  = glyph_n[0];
            seg_d[SEG_DP] = ~disp_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            phase_q    <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_q     <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_q      <= '1;
            tick_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            tick_q     <= tick_d;
            ready_q    <= ready_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_out    = dig_q;
    assign frame_tick = tick_q;
    assign load_ready = ready_q;

endmodule
